m_load_de: RTL and testbench
============================

Name: m_load_de

Overview:
- M-stage load unit: the read-side counterpart of the store byte-enable/lane-placement logic.
- Accepts a load request (op + byte address), issues a word-aligned read on the data-memory bus with byte enables, and waits for the returned word.
- Extracts the addressed byte/half-word, sign- or zero-extends it, and returns the result to the pipeline over a valid/ready handshake.
- Flags misaligned accesses, illegal ops and memory timeouts as errors.

Parameters:
- TIMEOUT, 16: max cycles from entering REQ to rdata return; 0 disables timeout.
- CNT_W, 5: timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  load request valid.
- o_ready  output  1  unit can accept a request.
- i_deOp  input  3  load op: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; 5-7 illegal.
- i_Addr  input  32  byte address.
- o_m_rd_req  output  1  memory read request.
- o_m_rd_addr  output  32  {i_Addr[31:2], 2'b00}, captured at accept.
- o_m_rd_byteen  output  4  lanes read: LW 1111; LH/LHU 0011 or 1100 by addr[1]; LB/LBU one-hot 0001<<addr[1:0].
- i_m_rd_ack  input  1  memory accepted request.
- i_m_rd_valid  input  1  read data valid.
- i_m_rd_data  input  32  read word.
- o_resp_valid  output  1  result valid.
- i_resp_ready  input  1  pipeline accepts result.
- o_resp_data  output  32  extended load result.
- o_resp_err  output  1  misaligned, illegal op, or timeout.

Behaviour:
- Clock/reset: one clock i_clk; reset i_rst_n asynchronous, active-low.
- Reset values:
  - State IDLE.
  - o_ready=1, o_m_rd_req=0, o_resp_valid=0, o_resp_err=0.
  - o_resp_data=0, o_m_rd_addr=0, o_m_rd_byteen=0.
  - Timeout counter=0.
- Reset mid-operation: abandons the transaction; no response is produced. Any later i_m_rd_valid is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - o_ready=1.
  - On i_valid: capture op, address and byteen.
  - Misaligned (LW with addr[1:0]!=0; LH/LHU with addr[0]!=0) or illegal op → RESP with err=1, data=0, no memory access.
  - Otherwise → REQ.
- REQ:
  - o_m_rd_req=1; addr and byteen held stable until ack.
  - i_m_rd_ack with i_m_rd_valid in the same cycle → RESP with extracted data.
  - i_m_rd_ack alone → WAIT.
- WAIT:
  - o_m_rd_req=0.
  - i_m_rd_valid → RESP with extracted data, err=0.
- Timeout (TIMEOUT>0):
  - Counter clears on accept and increments every cycle in REQ or WAIT.
  - When counter==TIMEOUT-1 and no completing event occurs that cycle → RESP with err=1, data=0, o_m_rd_req dropped.
  - Completion in that same cycle wins over timeout.
- RESP:
  - o_resp_valid=1; data/err held stable until i_resp_ready.
  - On i_resp_ready → IDLE.
- o_ready is 1 only in IDLE, so no request overlaps a response. Accepts one cycle after a handshake is possible; no same-cycle bypass.
- i_m_rd_valid outside REQ/WAIT is ignored; late data after a timeout is dropped.
- Extraction (registered on entry to RESP):
  - LW: word as is.
  - LH/LHU: addr[1]=0 selects [15:0], 1 selects [31:16].
  - LB/LBU: addr[1:0] selects [7:0], [15:8], [23:16], [31:24].
  - LH/LB sign-extend to 32 bits; LHU/LBU zero-extend.
- Latency:
  - Accept → o_resp_valid: minimum 2 cycles (ack+valid in first REQ cycle).
  - Error path: 1 cycle.

Test Plan:
- LB, addr 0x1003; memory acks and returns 0x80FF1234 the next cycle → byteen 1000, rd_addr 0x1000, resp_data 0xFFFFFF80, err=0.
- LBU same stimulus → resp_data 0x00000080; LHU addr 0x2 with data 0x80017FFF → 0x00008001; LH same → 0xFFFF8001; LW addr 0x8, data 0xDEADBEEF → 0xDEADBEEF.
- LW addr 0x6 or LH addr 0x3 → no o_m_rd_req ever; o_resp_valid one cycle after accept, err=1, data 0. Op 7 → same error response.
- TIMEOUT=4, ack given, i_m_rd_valid never asserted → o_resp_valid with err=1, data 0 after the counter expires. Then a late rd_valid arrives in IDLE → ignored, no second response.
- Backpressure: hold i_resp_ready=0 for 5 cycles → o_resp_valid/data stable, o_ready=0, new i_valid not accepted. Assert ready → IDLE next cycle, next request accepted.
- Assert i_rst_n low while in WAIT → all outputs immediately at reset values. Rd_valid after reset release is ignored; a fresh LB completes normally.

Source files
------------

// File: rtl/m_load_de.sv
// M-stage load unit: issues a word-aligned data-memory read with byte enables,
// then extracts and sign/zero-extends the addressed byte, half-word or word and
// returns it over a valid/ready handshake. Misaligned or illegal requests and
// memory timeouts come back as error responses with zero data.
module m_load_de #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [2:0]  i_deOp,
    input  logic [31:0] i_Addr,
    output logic        o_m_rd_req,
    output logic [31:0] o_m_rd_addr,
    output logic [3:0]  o_m_rd_byteen,
    input  logic        i_m_rd_ack,
    input  logic        i_m_rd_valid,
    input  logic [31:0] i_m_rd_data,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_data,
    output logic        o_resp_err
);

    localparam logic [2:0] OpLw  = 3'd0;
    localparam logic [2:0] OpLh  = 3'd1;
    localparam logic [2:0] OpLhu = 3'd2;
    localparam logic [2:0] OpLb  = 3'd3;
    localparam logic [2:0] OpLbu = 3'd4;

    // Last counter value still inside the timeout window; unused when TIMEOUT is 0.
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } state_e;

    state_e           state_q;
    logic [2:0]       op_q;
    logic [1:0]       addr_lo_q;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0]  req_byteen;
    logic        req_bad;
    logic        timeout_hit;
    logic [15:0] sel_half;
    logic [7:0]  sel_byte;
    logic [31:0] ext_data;

    // Decode the incoming request: lane enables and misaligned/illegal detection.
    always_comb begin
        req_byteen = 4'b0000;
        req_bad    = 1'b0;
        unique case (i_deOp)
            OpLw: begin
                req_byteen = 4'b1111;
                req_bad    = (i_Addr[1:0] != 2'b00);
            end
            OpLh, OpLhu: begin
                req_byteen = i_Addr[1] ? 4'b1100 : 4'b0011;
                req_bad    = i_Addr[0];
            end
            OpLb, OpLbu: begin
                req_byteen = 4'b0001 << i_Addr[1:0];
            end
            default: begin
                req_bad = 1'b1;
            end
        endcase
    end

    // Timeout fires on the last in-window cycle unless completion also happens then.
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (cnt_q == TimeoutLast);
    end

    // Lane selection and extension of the returned word using the captured op/address.
    always_comb begin
        sel_half = addr_lo_q[1] ? i_m_rd_data[31:16] : i_m_rd_data[15:0];
        unique case (addr_lo_q)
            2'd0:    sel_byte = i_m_rd_data[7:0];
            2'd1:    sel_byte = i_m_rd_data[15:8];
            2'd2:    sel_byte = i_m_rd_data[23:16];
            default: sel_byte = i_m_rd_data[31:24];
        endcase
        unique case (op_q)
            OpLw:    ext_data = i_m_rd_data;
            OpLh:    ext_data = {{16{sel_half[15]}}, sel_half};
            OpLhu:   ext_data = {16'h0000, sel_half};
            OpLb:    ext_data = {{24{sel_byte[7]}}, sel_byte};
            OpLbu:   ext_data = {24'h000000, sel_byte};
            default: ext_data = 32'h0000_0000;
        endcase
    end

    // Control FSM with all handshake and bus outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= StIdle;
            op_q          <= OpLw;
            addr_lo_q     <= 2'b00;
            cnt_q         <= '0;
            o_ready       <= 1'b1;
            o_m_rd_req    <= 1'b0;
            o_m_rd_addr   <= 32'h0000_0000;
            o_m_rd_byteen <= 4'b0000;
            o_resp_valid  <= 1'b0;
            o_resp_data   <= 32'h0000_0000;
            o_resp_err    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        op_q          <= i_deOp;
                        addr_lo_q     <= i_Addr[1:0];
                        o_m_rd_addr   <= {i_Addr[31:2], 2'b00};
                        o_m_rd_byteen <= req_byteen;
                        cnt_q         <= '0;
                        o_ready       <= 1'b0;
                        if (req_bad) begin
                            // Rejected without touching memory.
                            state_q      <= StResp;
                            o_resp_valid <= 1'b1;
                            o_resp_data  <= 32'h0000_0000;
                            o_resp_err   <= 1'b1;
                        end else begin
                            state_q    <= StReq;
                            o_m_rd_req <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (i_m_rd_ack && i_m_rd_valid) begin
                        state_q      <= StResp;
                        o_m_rd_req   <= 1'b0;
                        o_resp_valid <= 1'b1;
                        o_resp_data  <= ext_data;
                        o_resp_err   <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q      <= StResp;
                        o_m_rd_req   <= 1'b0;
                        o_resp_valid <= 1'b1;
                        o_resp_data  <= 32'h0000_0000;
                        o_resp_err   <= 1'b1;
                    end else if (i_m_rd_ack) begin
                        state_q    <= StWait;
                        o_m_rd_req <= 1'b0;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (i_m_rd_valid) begin
                        state_q      <= StResp;
                        o_resp_valid <= 1'b1;
                        o_resp_data  <= ext_data;
                        o_resp_err   <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q      <= StResp;
                        o_resp_valid <= 1'b1;
                        o_resp_data  <= 32'h0000_0000;
                        o_resp_err   <= 1'b1;
                    end
                end
                StResp: begin
                    // Data/err stay put after the handshake; only valid drops.
                    if (i_resp_ready) begin
                        state_q      <= StIdle;
                        o_resp_valid <= 1'b0;
                        o_ready      <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_load_de.sv
// Directed bench for m_load_de: loads of every width, error paths, timeout,
// backpressure and reset in the middle of a transaction.
module tb_m_load_de;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic [2:0]  de_op;
    logic [31:0] addr;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [3:0]  rd_byteen;
    logic        rd_ack;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    int total = 0;
    int bad   = 0;

    m_load_de #(
        .TIMEOUT(4),
        .CNT_W  (3)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (valid),
        .o_ready      (ready),
        .i_deOp       (de_op),
        .i_Addr       (addr),
        .o_m_rd_req   (rd_req),
        .o_m_rd_addr  (rd_addr),
        .o_m_rd_byteen(rd_byteen),
        .i_m_rd_ack   (rd_ack),
        .i_m_rd_valid (rd_valid),
        .i_m_rd_data  (rd_data),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_data  (resp_data),
        .o_resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_data;
        logic        fast;
    } ld_vec_t;

    // Advance one clock; sampling and driving happen 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total += 7;
        if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
        if (rd_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", rd_req); end
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", resp_valid); end
        if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", resp_err); end
        if (resp_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", resp_data); end
        if (rd_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", rd_addr); end
        if (rd_byteen !== 4'h0) begin bad++; $display("FAIL reset_be: got %b want 0000", rd_byteen); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_loads();
        ld_vec_t v[7];
        v[0] = '{3'd3, 32'h1003, 32'h80FF1234, 32'h1000, 4'b1000, 32'hFFFFFF80, 1'b0};
        v[1] = '{3'd4, 32'h1003, 32'h80FF1234, 32'h1000, 4'b1000, 32'h00000080, 1'b0};
        v[2] = '{3'd2, 32'h0002, 32'h80017FFF, 32'h0000, 4'b1100, 32'h00008001, 1'b0};
        v[3] = '{3'd1, 32'h0002, 32'h80017FFF, 32'h0000, 4'b1100, 32'hFFFF8001, 1'b0};
        v[4] = '{3'd0, 32'h0008, 32'hDEADBEEF, 32'h0008, 4'b1111, 32'hDEADBEEF, 1'b0};
        v[5] = '{3'd3, 32'h1001, 32'h80FF1234, 32'h1000, 4'b0010, 32'h00000012, 1'b1};
        v[6] = '{3'd1, 32'h0004, 32'h0000F00D, 32'h0004, 4'b0011, 32'hFFFFF00D, 1'b1};
        for (int i = 0; i < 7; i++) begin
            valid = 1'b1;
            de_op = v[i].op;
            addr  = v[i].a;
            tick();
            valid = 1'b0;
            total += 4;
            if (rd_req !== 1'b1) begin bad++; $display("FAIL load%0d_req: got %b want 1", i, rd_req); end
            if (rd_addr !== v[i].exp_addr) begin bad++; $display("FAIL load%0d_addr: got %h want %h", i, rd_addr, v[i].exp_addr); end
            if (rd_byteen !== v[i].exp_be) begin bad++; $display("FAIL load%0d_be: got %b want %b", i, rd_byteen, v[i].exp_be); end
            if (ready !== 1'b0) begin bad++; $display("FAIL load%0d_busy: got %b want 0", i, ready); end
            if (v[i].fast) begin
                rd_ack   = 1'b1;
                rd_valid = 1'b1;
                rd_data  = v[i].rdata;
                tick();
                rd_ack   = 1'b0;
                rd_valid = 1'b0;
            end else begin
                rd_ack = 1'b1;
                tick();
                rd_ack = 1'b0;
                total++;
                if (rd_req !== 1'b0) begin bad++; $display("FAIL load%0d_req_drop: got %b want 0", i, rd_req); end
                rd_valid = 1'b1;
                rd_data  = v[i].rdata;
                tick();
                rd_valid = 1'b0;
            end
            total += 3;
            if (resp_valid !== 1'b1) begin bad++; $display("FAIL load%0d_rvalid: got %b want 1", i, resp_valid); end
            if (resp_data !== v[i].exp_data) begin bad++; $display("FAIL load%0d_data: got %h want %h", i, resp_data, v[i].exp_data); end
            if (resp_err !== 1'b0) begin bad++; $display("FAIL load%0d_err: got %b want 0", i, resp_err); end
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
            total += 2;
            if (ready !== 1'b1) begin bad++; $display("FAIL load%0d_idle: got %b want 1", i, ready); end
            if (resp_valid !== 1'b0) begin bad++; $display("FAIL load%0d_rvalid_drop: got %b want 0", i, resp_valid); end
        end
    endtask

    task automatic test_errors();
        logic [2:0]  ops[4];
        logic [31:0] as[4];
        ops[0] = 3'd0; as[0] = 32'h0006;
        ops[1] = 3'd1; as[1] = 32'h0003;
        ops[2] = 3'd7; as[2] = 32'h0000;
        ops[3] = 3'd2; as[3] = 32'h0101;
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            de_op = ops[i];
            addr  = as[i];
            tick();
            valid = 1'b0;
            total += 4;
            if (rd_req !== 1'b0) begin bad++; $display("FAIL err%0d_req: got %b want 0", i, rd_req); end
            if (resp_valid !== 1'b1) begin bad++; $display("FAIL err%0d_rvalid: got %b want 1", i, resp_valid); end
            if (resp_err !== 1'b1) begin bad++; $display("FAIL err%0d_err: got %b want 1", i, resp_err); end
            if (resp_data !== 32'h0) begin bad++; $display("FAIL err%0d_data: got %h want 0", i, resp_data); end
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
            total += 2;
            if (rd_req !== 1'b0) begin bad++; $display("FAIL err%0d_req_after: got %b want 0", i, rd_req); end
            if (ready !== 1'b1) begin bad++; $display("FAIL err%0d_idle: got %b want 1", i, ready); end
        end
    endtask

    task automatic test_timeout();
        int n;
        // Ack then silence: expires three cycles after the ack cycle.
        valid = 1'b1;
        de_op = 3'd0;
        addr  = 32'h0010;
        tick();
        valid  = 1'b0;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total += 3;
        if (n !== 3) begin bad++; $display("FAIL to_wait_cycles: got %0d want 3", n); end
        if (resp_err !== 1'b1) begin bad++; $display("FAIL to_wait_err: got %b want 1", resp_err); end
        if (resp_data !== 32'h0) begin bad++; $display("FAIL to_wait_data: got %h want 0", resp_data); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        // Late data in IDLE must not produce a response.
        rd_valid = 1'b1;
        rd_data  = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            tick();
            total += 2;
            if (resp_valid !== 1'b0) begin bad++; $display("FAIL to_late%0d_rvalid: got %b want 0", i, resp_valid); end
            if (ready !== 1'b1) begin bad++; $display("FAIL to_late%0d_ready: got %b want 1", i, ready); end
        end
        rd_valid = 1'b0;
        // No ack at all: request held through the window, then dropped.
        valid = 1'b1;
        de_op = 3'd3;
        addr  = 32'h0021;
        tick();
        valid = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            total++;
            if (rd_req !== 1'b1) begin bad++; $display("FAIL to_req_hold%0d: got %b want 1", n, rd_req); end
            tick();
            n++;
        end
        total += 3;
        if (n !== 4) begin bad++; $display("FAIL to_req_cycles: got %0d want 4", n); end
        if (rd_req !== 1'b0) begin bad++; $display("FAIL to_req_drop: got %b want 0", rd_req); end
        if (resp_err !== 1'b1) begin bad++; $display("FAIL to_req_err: got %b want 1", resp_err); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        // Completion on the final in-window cycle beats the timeout.
        valid = 1'b1;
        de_op = 3'd4;
        addr  = 32'h0030;
        tick();
        valid  = 1'b0;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        tick();
        tick();
        rd_valid = 1'b1;
        rd_data  = 32'h000000AB;
        tick();
        rd_valid = 1'b0;
        total += 3;
        if (resp_valid !== 1'b1) begin bad++; $display("FAIL to_race_rvalid: got %b want 1", resp_valid); end
        if (resp_err !== 1'b0) begin bad++; $display("FAIL to_race_err: got %b want 0", resp_err); end
        if (resp_data !== 32'h000000AB) begin bad++; $display("FAIL to_race_data: got %h want 000000ab", resp_data); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        valid = 1'b1;
        de_op = 3'd0;
        addr  = 32'h000C;
        tick();
        valid    = 1'b0;
        rd_ack   = 1'b1;
        rd_valid = 1'b1;
        rd_data  = 32'h12345678;
        tick();
        rd_ack   = 1'b0;
        rd_valid = 1'b0;
        // New request offered while the response is stalled.
        valid = 1'b1;
        de_op = 3'd3;
        addr  = 32'h0020;
        for (int i = 0; i < 5; i++) begin
            total += 4;
            if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp%0d_rvalid: got %b want 1", i, resp_valid); end
            if (resp_data !== 32'h12345678) begin bad++; $display("FAIL bp%0d_data: got %h want 12345678", i, resp_data); end
            if (ready !== 1'b0) begin bad++; $display("FAIL bp%0d_ready: got %b want 0", i, ready); end
            if (rd_req !== 1'b0) begin bad++; $display("FAIL bp%0d_req: got %b want 0", i, rd_req); end
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        total += 3;
        if (ready !== 1'b1) begin bad++; $display("FAIL bp_idle_ready: got %b want 1", ready); end
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_idle_rvalid: got %b want 0", resp_valid); end
        if (rd_req !== 1'b0) begin bad++; $display("FAIL bp_idle_req: got %b want 0", rd_req); end
        tick();
        valid = 1'b0;
        total += 3;
        if (rd_req !== 1'b1) begin bad++; $display("FAIL bp_next_req: got %b want 1", rd_req); end
        if (rd_addr !== 32'h0020) begin bad++; $display("FAIL bp_next_addr: got %h want 00000020", rd_addr); end
        if (rd_byteen !== 4'b0001) begin bad++; $display("FAIL bp_next_be: got %b want 0001", rd_byteen); end
        rd_ack   = 1'b1;
        rd_valid = 1'b1;
        rd_data  = 32'h0000007F;
        tick();
        rd_ack   = 1'b0;
        rd_valid = 1'b0;
        total++;
        if (resp_data !== 32'h0000007F) begin bad++; $display("FAIL bp_next_data: got %h want 0000007f", resp_data); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        valid = 1'b1;
        de_op = 3'd0;
        addr  = 32'h0040;
        tick();
        valid  = 1'b0;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        rst_n  = 1'b0;
        #1;
        total += 7;
        if (ready !== 1'b1) begin bad++; $display("FAIL rm_ready: got %b want 1", ready); end
        if (rd_req !== 1'b0) begin bad++; $display("FAIL rm_req: got %b want 0", rd_req); end
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL rm_rvalid: got %b want 0", resp_valid); end
        if (resp_err !== 1'b0) begin bad++; $display("FAIL rm_err: got %b want 0", resp_err); end
        if (resp_data !== 32'h0) begin bad++; $display("FAIL rm_data: got %h want 0", resp_data); end
        if (rd_addr !== 32'h0) begin bad++; $display("FAIL rm_addr: got %h want 0", rd_addr); end
        if (rd_byteen !== 4'h0) begin bad++; $display("FAIL rm_be: got %b want 0000", rd_byteen); end
        tick();
        rst_n    = 1'b1;
        rd_valid = 1'b1;
        rd_data  = 32'h11111111;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (resp_valid !== 1'b0) begin bad++; $display("FAIL rm_late%0d_rvalid: got %b want 0", i, resp_valid); end
        end
        rd_valid = 1'b0;
        valid = 1'b1;
        de_op = 3'd3;
        addr  = 32'h1002;
        tick();
        valid = 1'b0;
        total++;
        if (rd_byteen !== 4'b0100) begin bad++; $display("FAIL rm_lb_be: got %b want 0100", rd_byteen); end
        rd_ack = 1'b1;
        tick();
        rd_ack   = 1'b0;
        rd_valid = 1'b1;
        rd_data  = 32'h00800000;
        tick();
        rd_valid = 1'b0;
        total += 3;
        if (resp_valid !== 1'b1) begin bad++; $display("FAIL rm_lb_rvalid: got %b want 1", resp_valid); end
        if (resp_data !== 32'hFFFFFF80) begin bad++; $display("FAIL rm_lb_data: got %h want ffffff80", resp_data); end
        if (resp_err !== 1'b0) begin bad++; $display("FAIL rm_lb_err: got %b want 0", resp_err); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        valid      = 1'b0;
        de_op      = 3'd0;
        addr       = 32'h0;
        rd_ack     = 1'b0;
        rd_valid   = 1'b0;
        rd_data    = 32'h0;
        resp_ready = 1'b0;
        test_reset();
        test_loads();
        test_errors();
        test_timeout();
        test_backpressure();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
